// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MULT  = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider.
// Purely combinational; a single WIDTH+1-bit adder serves both modes
// (subtraction done as add of the inverted operand plus carry-in).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] breg,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] rem;
    logic [WIDTH:0] opa;
    logic [WIDTH:0] opb;
    logic [WIDTH:0] res;

    // Select operands, run the shared adder/subtractor and form the shifted result.
    always_comb begin
        rem = {acc_hi, acc_lo[WIDTH-1]};
        opa = mode_div ? rem : {1'b0, acc_hi};
        opb = (mode_div || acc_lo[0]) ? {1'b0, breg} : '0;
        res = opa + (mode_div ? ~opb : opb) + {{WIDTH{1'b0}}, mode_div};
        if (mode_div) begin
            // res[WIDTH] set means the trial subtraction borrowed: restore.
            next_hi = res[WIDTH] ? rem[WIDTH-1:0] : res[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], ~res[WIDTH]};
        end else begin
            next_hi = res[WIDTH:1];
            next_lo = {res[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide controller with architectural HI/LO registers.
// One result bit per cycle over WIDTH cycles, then a fix/commit cycle.
// Optional signed MULT/DIV support is built when MULDIV_SIGNED_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   breg;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic               mode_div;
    logic               op_md;
    logic               accept_md;
    logic               accept_mt;
`ifdef MULDIV_SIGNED_EN
    logic               sign_a;
    logic               sign_b;
    logic               neg_a;
    logic               neg_b;
`endif

    assign busy = (state != ST_IDLE);

    // Decode legal mul/div ops and form the operand values captured on accept.
    always_comb begin
        op_md = (op == OP_MULTU) || (op == OP_DIVU);
        cap_a = srca;
        cap_b = srcb;
`ifdef MULDIV_SIGNED_EN
        op_md = op_md || (op == OP_MULT) || (op == OP_DIV);
        neg_a = op[2] && srca[WIDTH-1];
        neg_b = op[2] && srcb[WIDTH-1];
        if (neg_a) cap_a = -srca;
        if (neg_b) cap_b = -srcb;
`endif
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Next-state and accept decode; flush overrides every transition.
    always_comb begin
        state_n   = state;
        accept_md = 1'b0;
        accept_mt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (op_md) begin
                        accept_md = 1'b1;
                        state_n   = ST_RUN;
                    end else if (op == OP_MTHI || op == OP_MTLO) begin
                        accept_mt = 1'b1;
                    end
                end
            end
            // Leave RUN on the edge where the count reaches WIDTH.
            ST_RUN:  if (cnt == CW'(WIDTH - 1)) state_n = ST_FIX;
            ST_FIX:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_IDLE;
    end

    // Sign fix and divide-by-zero override applied to the finished working registers.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (mode_div) begin
`ifdef MULDIV_SIGNED_EN
            if (sign_a ^ sign_b) fix_lo = -acc_lo;
            if (sign_a)          fix_hi = -acc_hi;
`endif
            // With a zero divisor the remainder path has shifted the whole
            // dividend into acc_hi, so only the quotient needs forcing.
            if (breg == '0) fix_lo = '1;
        end else begin
`ifdef MULDIV_SIGNED_EN
            if (sign_a ^ sign_b) prod = -prod;
`endif
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_div (mode_div),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .breg     (breg),
        .next_hi  (step_hi),
        .next_lo  (step_lo)
    );

    // Working registers, counter, HI/LO and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            breg        <= '0;
            mode_div    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                cnt      <= '0;
                acc_hi   <= '0;
                acc_lo   <= '0;
                breg     <= '0;
                mode_div <= 1'b0;
`ifdef MULDIV_SIGNED_EN
                sign_a   <= 1'b0;
                sign_b   <= 1'b0;
`endif
            end else begin
                if (accept_md) begin
                    cnt      <= '0;
                    acc_hi   <= '0;
                    acc_lo   <= cap_a;
                    breg     <= cap_b;
                    mode_div <= op[0];
`ifdef MULDIV_SIGNED_EN
                    sign_a   <= neg_a;
                    sign_b   <= neg_b;
`endif
                end
                if (accept_mt) begin
                    if (op == OP_MTHI) hi <= srca;
                    else               lo <= srca;
                end
                if (state == ST_RUN) begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                end
                if (state == ST_FIX) begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                    if (mode_div) div_by_zero <= (breg == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference of HI/LO/div_by_zero.
// Honours MULDIV_SIGNED_EN to select signed-op expectations.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .srca        (srca),
        .srcb        (srcb),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_md(input logic [2:0] o);
`ifdef MULDIV_SIGNED_EN
        return o inside {3'd0, 3'd1, 3'd4, 3'd5};
`else
        return o inside {3'd0, 3'd1};
`endif
    endfunction

    // Expected HI/LO/div_by_zero after op o completes, from plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint      sa, sb, q, r;
        logic [63:0] p;
        eh = m_hi;
        el = m_lo;
        ed = m_dz;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
            3'd1: begin
                if (b == 0) begin el = '1; eh = a; ed = 1'b1; end
                else begin el = a / b; eh = a % b; ed = 1'b0; end
            end
            3'd2: eh = a;
            3'd3: el = a;
`ifdef MULDIV_SIGNED_EN
            3'd4: begin p = sa * sb; {eh, el} = p; end
            3'd5: begin
                if (b == 0) begin el = '1; eh = a; ed = 1'b1; end
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                    ed = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    endtask

    // Issue one op at the current negedge and follow it to completion.
    // poke_at > 0 drives a competing MULTU start in that busy cycle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at);
        logic [W-1:0] eh, el;
        logic         ed;
        int           n, nbusy;
        bit           both;
        model(o, a, b, eh, el, ed);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); srca = $urandom; srcb = $urandom;
        if (is_md(o)) begin
            nbusy = 0;
            both  = 1'b0;
            for (n = 1; n <= 40; n++) begin
                if (busy && done) both = 1'b1;
                if (done) break;
                if (busy) nbusy++;
                if (n == 16) begin
                    check("hold_hi", hi, m_hi);
                    check("hold_lo", lo, m_lo);
                end
                start = (n == poke_at);
                op = 3'd0; srca = $urandom; srcb = $urandom;
                @(negedge clk);
            end
            start = 1'b0;
            check("latency", n - 1, 33);
            check("busy_cycles", nbusy, 33);
            check("busy_done_excl", both, 0);
        end else begin
            check("no_busy", busy, 0);
            check("no_done", done, 0);
        end
        m_hi = eh; m_lo = el; m_dz = ed;
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("dz", div_by_zero, m_dz);
    endtask

    // Issue an op and flush it k cycles after acceptance.
    task automatic run_flush(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int k);
        int seen = 0;
        start = 1'b1; op = o; srca = a; srcb = b;
        repeat (k) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", busy, 0);
        repeat (40) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        check("flush_quiet", seen, 0);
        check("flush_hi", hi, m_hi);
        check("flush_lo", lo, m_lo);
        check("flush_dz", div_by_zero, m_dz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'd100, 32'd7, 0);
        run_op(3'd1, 32'h1234, 32'd0, 0);

        // MTHI then MTLO in consecutive cycles
        start = 1'b1; op = 3'd2; srca = 32'hA5A5_A5A5;
        @(negedge clk);
        op = 3'd3; srca = 32'h5A5A_5A5A;
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo", lo, m_lo);
        check("mthi_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h5A5A_5A5A);
        check("mtlo_done", done, 0);
        check("mtlo_busy", busy, 0);
        m_hi = 32'hA5A5_A5A5; m_lo = 32'h5A5A_5A5A;

        run_op(3'd1, 32'hDEAD_BEEF, 32'h13, 5);
        run_flush(3'd1, 32'h5555, 32'd3, 10);
        run_flush(3'd0, 32'h12345, 32'd77, 33);

        // flush and start together: start is dropped
        flush = 1'b1; start = 1'b1; op = 3'd2; srca = 32'h0BAD_F00D;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("fs_hi", hi, m_hi);
        check("fs_busy", busy, 0);

        run_op(3'd6, 32'h1111_1111, 32'h2, 0);
        run_op(3'd7, 32'h2222_2222, 32'h3, 0);
        run_op(3'd4, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd1, 32'd5, 32'd9, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if (is_md(ro) && $urandom_range(0, 9) == 0) run_flush(ro, ra, rb, $urandom_range(1, 33));
            else                                        run_op(ro, ra, rb, 0);
        end

        // asynchronous reset in the middle of a run, with div_by_zero set
        run_op(3'd1, 32'd77, 32'd0, 0);
        start = 1'b1; op = 3'd0; srca = 32'h1357_9BDF; srcb = 32'h2468_ACE0;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_dz", div_by_zero, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(3'd1, 32'd100, 32'd7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
